// File: rtl/j1_io_pkg.sv
// Shared types and constants for the J1 I/O fabric: FSM states, status page layout, flag bits.
package j1_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } io_state_t;

    localparam int STAT_OFF_FLAGS    = 0;
    localparam int STAT_OFF_ERR_ADDR = 1;
    localparam int STAT_OFF_COUNT    = 2;

    localparam int FLAG_UNMAPPED = 0;
    localparam int FLAG_TIMEOUT  = 1;

    localparam logic [15:0] IO_DEFAULT_DATA = 16'h0666;

endpackage

// File: rtl/io_wait_timer.sv
// Wait-state counter for slave accesses: cleared outside an access, counts unacked cycles,
// and holds once it reaches TIMEOUT.
module io_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/j1_io_fabric.sv
// J1 I/O interconnect: page decode onto NUM_SLAVES slave channels, ack wait with timeout,
// unmapped/timeout error trapping and a status page (flags, first error address, transaction count).
module j1_io_fabric
    import j1_io_pkg::*;
#(
    parameter int                 NUM_SLAVES   = 4,
    parameter int                 DATA_W       = 16,
    parameter int                 ADDR_W       = 16,
    parameter int                 PAGE_W       = 8,
    parameter logic [PAGE_W-1:0]  BASE_PAGE    = 8'h67,
    parameter logic [PAGE_W-1:0]  STATUS_PAGE  = 8'h7F,
    parameter int                 TIMEOUT      = 15,
    parameter logic [DATA_W-1:0]  DEFAULT_DATA = IO_DEFAULT_DATA
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic                         m_rd,
    input  logic                         m_wr,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_dout,
    output logic [DATA_W-1:0]            m_din,
    output logic                         m_busy,
    output logic [NUM_SLAVES-1:0]        s_cs,
    output logic                         s_rd,
    output logic                         s_wr,
    output logic [ADDR_W-PAGE_W-1:0]     s_addr,
    output logic [DATA_W-1:0]            s_dout,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_din,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    localparam int OFF_W = ADDR_W - PAGE_W;
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [PAGE_W-1:0] SLAVE_SPAN = PAGE_W'(NUM_SLAVES);

    io_state_t          r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_err_addr;
    logic [1:0]         r_flags;
    logic [DATA_W-1:0]  r_count;

    logic [PAGE_W-1:0]  w_page;
    logic [PAGE_W-1:0]  w_slot;
    logic [OFF_W-1:0]   w_off;
    logic               w_req;
    logic               w_hit;
    logic               w_status;
    logic               w_ack;
    logic               w_expired;
    logic               w_err_free;
    logic [DATA_W-1:0]  w_sel_din;
    logic [DATA_W-1:0]  w_status_rd;

    // Unsigned wrap of page - BASE_PAGE makes pages below the base land far outside the span.
    always_comb begin
        w_page     = m_addr[ADDR_W-1 -: PAGE_W];
        w_off      = m_addr[OFF_W-1:0];
        w_slot     = w_page - BASE_PAGE;
        w_hit      = (w_slot < SLAVE_SPAN);
        w_status   = (w_page == STATUS_PAGE);
        w_req      = (m_rd || m_wr) && (r_state != ACCESS);
        w_ack      = s_ack[r_sel];
        w_sel_din  = s_din[int'(r_sel) * DATA_W +: DATA_W];
        w_err_free = (r_flags == 2'b00);
    end

    always_comb begin
        w_status_rd = '0;
        if (w_off == OFF_W'(STAT_OFF_FLAGS)) begin
            w_status_rd = DATA_W'(r_flags);
        end else if (w_off == OFF_W'(STAT_OFF_ERR_ADDR)) begin
            w_status_rd = DATA_W'(r_err_addr);
        end else if (w_off == OFF_W'(STAT_OFF_COUNT)) begin
            w_status_rd = r_count;
        end
    end

    io_wait_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (sys_clk_i),
        .i_rst     (sys_rst_i),
        .i_clear   (r_state != ACCESS),
        .i_enable  ((r_state == ACCESS) && !w_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_err_addr <= '0;
            r_flags    <= '0;
            r_count    <= '0;
            m_din      <= '0;
            s_cs       <= '0;
            s_rd       <= 1'b0;
            s_wr       <= 1'b0;
            s_addr     <= '0;
            s_dout     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_req) begin
                        r_state <= DONE;
                        if (w_hit) begin
                            r_state <= ACCESS;
                            r_sel   <= w_slot[SEL_W-1:0];
                            r_write <= m_wr;
                            r_addr  <= m_addr;
                            s_cs    <= NUM_SLAVES'(1) << w_slot;
                            s_rd    <= !m_wr;
                            s_wr    <= m_wr;
                            s_addr  <= w_off;
                            s_dout  <= m_dout;
                        end else if (w_status) begin
                            if (!m_wr) begin
                                m_din <= w_status_rd;
                            end else if (w_off == OFF_W'(STAT_OFF_FLAGS)) begin
                                r_flags <= r_flags & ~m_dout[1:0];
                            end
                        end else begin
                            if (!m_wr) begin
                                m_din <= DEFAULT_DATA;
                            end
                            if (w_err_free) begin
                                r_err_addr <= m_addr;
                            end
                            r_flags[FLAG_UNMAPPED] <= 1'b1;
                            r_count <= r_count + DATA_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final wait cycle still wins over the timeout.
                    if (w_ack || w_expired) begin
                        r_state <= DONE;
                        s_cs    <= '0;
                        s_rd    <= 1'b0;
                        s_wr    <= 1'b0;
                        r_count <= r_count + DATA_W'(1);
                        if (w_ack) begin
                            if (!r_write) begin
                                m_din <= w_sel_din;
                            end
                        end else begin
                            if (!r_write) begin
                                m_din <= DEFAULT_DATA;
                            end
                            if (w_err_free) begin
                                r_err_addr <= r_addr;
                            end
                            r_flags[FLAG_TIMEOUT] <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_busy = (r_state == ACCESS);

endmodule

// File: tb/tb_j1_io_fabric.sv
// Self-checking bench for j1_io_fabric: vector table run through a read-data scoreboard,
// plus hand-written sequences for reset mid-access, strobes during ACCESS and back-to-back counting.
module tb_j1_io_fabric;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_dout;
    logic [15:0] m_din;
    logic        m_busy;
    logic [3:0]  s_cs;
    logic        s_rd;
    logic        s_wr;
    logic [7:0]  s_addr;
    logic [15:0] s_dout;
    logic [63:0] s_din;
    logic [3:0]  s_ack;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dout;
        int          ackWait;
        logic [15:0] slvData;
        logic [15:0] expDin;
        int          expCycles;
        logic [3:0]  expCs;
        logic        expSrd;
        logic        expSwr;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] expQ[$];

    j1_io_fabric dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_din     (m_din),
        .m_busy    (m_busy),
        .s_cs      (s_cs),
        .s_rd      (s_rd),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_dout    (s_dout),
        .s_din     (s_din),
        .s_ack     (s_ack)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic doReset();
        sys_rst_i = 1'b1;
        m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_dout = '0;
        s_ack = '0; s_din = '0;
        repeat (3) tick();
        sys_rst_i = 1'b0;
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] dout,
                          input int ackWait, input logic [15:0] slv, input logic [15:0] expDin,
                          input int expCycles, input logic [3:0] expCs);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.dout = dout;
        v.ackWait = ackWait; v.slvData = slv; v.expDin = expDin;
        v.expCycles = expCycles; v.expCs = expCs;
        v.expSrd = (expCs != 4'b0) && !wr;
        v.expSwr = (expCs != 4'b0) && wr;
        vecs.push_back(v);
    endtask

    // One access: the selected slave acks after ackWait cycles while the other slaves ack as noise.
    task automatic applyStimulus(input vec_t v);
        int          sel;
        int          n;
        logic [3:0]  oneHot;
        logic        held;
        logic [15:0] expD;
        sel    = int'(v.addr[15:8]) - 'h67;
        oneHot = (sel >= 0 && sel < 4) ? 4'(1 << sel) : 4'b0;
        for (int i = 0; i < 4; i++) s_din[i*16 +: 16] = (i == sel) ? v.slvData : 16'hD0D0 + 16'(i);
        m_rd = v.rd; m_wr = v.wr; m_addr = v.addr; m_dout = v.dout;
        expQ.push_back(v.expDin);
        tick();
        m_rd = 1'b0; m_wr = 1'b0;
        checkOutput($sformatf("s_cs@%h", v.addr), s_cs, v.expCs);
        checkOutput($sformatf("s_rd@%h", v.addr), s_rd, v.expSrd);
        checkOutput($sformatf("s_wr@%h", v.addr), s_wr, v.expSwr);
        if (v.expCs != 4'b0) begin
            checkOutput($sformatf("s_addr@%h", v.addr), s_addr, v.addr[7:0]);
            if (v.wr) checkOutput($sformatf("s_dout@%h", v.addr), s_dout, v.dout);
        end
        n = 0;
        held = 1'b1;
        while (m_busy && n < 40) begin
            if (s_cs !== v.expCs || s_rd !== v.expSrd || s_wr !== v.expSwr) held = 1'b0;
            s_ack = (n == v.ackWait) ? oneHot : ~oneHot;
            tick();
            n++;
        end
        s_ack = '0;
        checkOutput($sformatf("busy_cycles@%h", v.addr), n, v.expCycles);
        if (v.expCs != 4'b0) checkOutput($sformatf("held@%h", v.addr), held, 1);
        checkOutput($sformatf("s_cs_done@%h", v.addr), s_cs, 4'b0);
        expD = expQ.pop_front();
        checkOutput($sformatf("m_din@%h", v.addr), m_din, expD);
    endtask

    task automatic runVecs();
        for (int k = 0; k < vecs.size(); k++) applyStimulus(vecs[k]);
        vecs.delete();
    endtask

    initial begin
        doReset();
        checkOutput("rst_m_din", m_din, 16'h0);
        checkOutput("rst_m_busy", m_busy, 1'b0);
        checkOutput("rst_s_cs", s_cs, 4'b0);
        checkOutput("rst_strobes", {s_rd, s_wr}, 2'b00);
        checkOutput("rst_s_addr", s_addr, 8'h0);
        checkOutput("rst_s_dout", s_dout, 16'h0);

        //      rd    wr    addr      dout      ack  slave     expDin    cyc  cs
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h6904, 16'h0000,  0, 16'hBEEF, 16'hBEEF,  1, 4'b0100);
        addVec(1'b0, 1'b1, 16'h6701, 16'h1234,  3, 16'h0000, 16'hBEEF,  4, 4'b0001);
        addVec(1'b1, 1'b0, 16'h6800, 16'h0000, 99, 16'h4444, 16'h0666, 16, 4'b0010);
        addVec(1'b1, 1'b0, 16'h7F00, 16'h0000,  0, 16'h0000, 16'h0002,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F01, 16'h0000,  0, 16'h0000, 16'h6800,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0003,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h5500, 16'h0000,  0, 16'h0000, 16'h0666,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F00, 16'h0000,  0, 16'h0000, 16'h0003,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F01, 16'h0000,  0, 16'h0000, 16'h6800,  0, 4'b0000);
        addVec(1'b0, 1'b1, 16'h7F00, 16'h0003,  0, 16'h0000, 16'h6800,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F00, 16'h0000,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b0, 1'b1, 16'h7F02, 16'h5555,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0004,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F05, 16'h0000,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b0, 1'b1, 16'h6B00, 16'h1111,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F01, 16'h0000,  0, 16'h0000, 16'h6B00,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h6600, 16'h0000,  0, 16'h0000, 16'h0666,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F00, 16'h0000,  0, 16'h0000, 16'h0001,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h6A10, 16'h0000,  2, 16'hCAFE, 16'hCAFE,  3, 4'b1000);
        addVec(1'b1, 1'b1, 16'h6A00, 16'hA5A5,  0, 16'h0000, 16'hCAFE,  1, 4'b1000);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0008,  0, 4'b0000);
        runVecs();

        // Reset while waiting on an ack, then a late ack that must be ignored.
        s_din = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        m_rd = 1'b1; m_addr = 16'h6800;
        tick();
        m_rd = 1'b0;
        checkOutput("mid_busy", m_busy, 1'b1);
        checkOutput("mid_s_cs", s_cs, 4'b0010);
        tick();
        tick();
        sys_rst_i = 1'b1;
        tick();
        sys_rst_i = 1'b0;
        checkOutput("abort_s_cs", s_cs, 4'b0);
        checkOutput("abort_busy", m_busy, 1'b0);
        checkOutput("abort_s_rd", s_rd, 1'b0);
        checkOutput("abort_m_din", m_din, 16'h0);
        s_ack = 4'b1111;
        tick();
        tick();
        s_ack = '0;
        checkOutput("late_ack_busy", m_busy, 1'b0);
        checkOutput("late_ack_s_cs", s_cs, 4'b0);
        checkOutput("late_ack_m_din", m_din, 16'h0);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        addVec(1'b1, 1'b0, 16'h7F00, 16'h0000,  0, 16'h0000, 16'h0000,  0, 4'b0000);
        runVecs();

        // A write strobe during ACCESS is dropped rather than queued.
        s_din = {16'h3333, 16'h1357, 16'h1111, 16'h0000};
        m_rd = 1'b1; m_addr = 16'h6904;
        tick();
        m_rd = 1'b0;
        m_wr = 1'b1; m_addr = 16'h6701; m_dout = 16'hFFFF;
        tick();
        m_wr = 1'b0;
        checkOutput("ign_s_cs", s_cs, 4'b0100);
        checkOutput("ign_s_addr", s_addr, 8'h04);
        checkOutput("ign_strobes", {s_rd, s_wr}, 2'b10);
        checkOutput("ign_busy", m_busy, 1'b1);
        s_ack = 4'b0100;
        tick();
        s_ack = '0;
        checkOutput("ign_done_busy", m_busy, 1'b0);
        checkOutput("ign_m_din", m_din, 16'h1357);
        tick();
        checkOutput("ign_idle_busy", m_busy, 1'b0);
        checkOutput("ign_idle_s_cs", s_cs, 4'b0);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0001,  0, 4'b0000);
        runVecs();

        // Back-to-back accesses issued from DONE, counted from a fresh reset.
        doReset();
        addVec(1'b1, 1'b1, 16'h6A00, 16'h0F0F,  0, 16'h0000, 16'h0000,  1, 4'b1000);
        addVec(1'b1, 1'b0, 16'h6700, 16'h0000,  0, 16'h1111, 16'h1111,  1, 4'b0001);
        addVec(1'b1, 1'b0, 16'h6800, 16'h0000,  0, 16'h2222, 16'h2222,  1, 4'b0010);
        addVec(1'b1, 1'b0, 16'h6900, 16'h0000,  1, 16'h3333, 16'h3333,  2, 4'b0100);
        addVec(1'b1, 1'b0, 16'h7F02, 16'h0000,  0, 16'h0000, 16'h0004,  0, 4'b0000);
        runVecs();

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
